// File: rtl/skew_feed_buf.sv
// Multi-lane circular FIFO bank feeding one edge of the PE array; lane i is preloaded with
// i*SKEW zero words so a single broadcast pop presents skewed operands to the array.
module skew_feed_buf #(
    parameter int unsigned WORDLEN = 8,
    parameter int unsigned LANES   = 4,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned SKEW    = 1,
    localparam int unsigned LW     = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [LW-1:0]            wr_lane,
    input  logic [WORDLEN-1:0]       wr_data,
    input  logic                     rd_en,
    output logic [LANES*WORDLEN-1:0] rd_data,
    output logic [LANES-1:0]         lane_empty,
    output logic [LANES-1:0]         lane_full,
    output logic                     all_valid,
    output logic                     err_ovf,
    output logic                     err_udf
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [PW-1:0]      head_q [LANES];
    logic [PW-1:0]      head_d [LANES];
    logic [PW-1:0]      tail_q [LANES];
    logic [PW-1:0]      tail_d [LANES];
    logic [CW-1:0]      cnt_q  [LANES];
    logic [CW-1:0]      cnt_d  [LANES];
    logic [WORDLEN-1:0] mem_q  [LANES][DEPTH];
    logic [WORDLEN-1:0] mem_d  [LANES][DEPTH];
    logic               err_ovf_q, err_ovf_d;
    logic               err_udf_q, err_udf_d;

    logic [LANES-1:0]   lane_pop;
    logic [LANES-1:0]   lane_sel;
    logic [LANES-1:0]   lane_acc;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        rd_data    = '0;
        lane_empty = '0;
        lane_full  = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_empty[i] = (cnt_q[i] == '0);
            lane_full[i]  = (cnt_q[i] == CW'(DEPTH));
            // Stale storage remains at head after draining, so empty lanes are forced to zero.
            if (cnt_q[i] != '0) begin
                rd_data[i*WORDLEN +: WORDLEN] = mem_q[i][head_q[i]];
            end
        end
        all_valid = ~|lane_empty;
        err_ovf   = err_ovf_q;
        err_udf   = err_udf_q;
    end

    // A full lane still accepts a push when it is popped in the same cycle.
    always_comb begin
        lane_pop = '0;
        lane_sel = '0;
        lane_acc = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_pop[i] = rd_en && (cnt_q[i] != '0);
            lane_sel[i] = wr_en && (int'(wr_lane) == i);
            lane_acc[i] = lane_sel[i] && ((cnt_q[i] != CW'(DEPTH)) || lane_pop[i]);
        end
    end

    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        cnt_d     = cnt_q;
        mem_d     = mem_q;
        err_ovf_d = err_ovf_q;
        err_udf_d = err_udf_q;
        // Reset is synchronous, so it shares the flush re-initialisation path here.
        if (!rstn || flush) begin
            for (int i = 0; i < LANES; i++) begin
                head_d[i] = '0;
                tail_d[i] = PW'(i * SKEW);
                cnt_d[i]  = CW'(i * SKEW);
                for (int j = 0; j < DEPTH; j++) begin
                    mem_d[i][j] = '0;
                end
            end
            if (!rstn) begin
                err_ovf_d = 1'b0;
                err_udf_d = 1'b0;
            end
        end else begin
            if (rd_en && (|lane_empty)) begin
                err_udf_d = 1'b1;
            end
            if (|(lane_sel & ~lane_acc)) begin
                err_ovf_d = 1'b1;
            end
            for (int i = 0; i < LANES; i++) begin
                if (lane_acc[i]) begin
                    mem_d[i][tail_q[i]] = wr_data;
                    tail_d[i]           = ptr_inc(tail_q[i]);
                end
                if (lane_pop[i]) begin
                    head_d[i] = ptr_inc(head_q[i]);
                end
                if (lane_acc[i] && !lane_pop[i]) begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end else if (!lane_acc[i] && lane_pop[i]) begin
                    cnt_d[i] = cnt_q[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        head_q    <= head_d;
        tail_q    <= tail_d;
        cnt_q     <= cnt_d;
        mem_q     <= mem_d;
        err_ovf_q <= err_ovf_d;
        err_udf_q <= err_udf_d;
    end

endmodule

// File: tb/tb_skew_feed_buf.sv
// Directed bench for skew_feed_buf: a per-lane queue model predicts every output each cycle,
// plus a second small instance (LANES=3, DEPTH=5) covers out-of-range lanes and odd depth.
module tb_skew_feed_buf;

    localparam int W = 8;
    localparam int L = 4;
    localparam int D = 16;
    localparam int S = 1;

    logic          clk = 1'b0;
    logic          rstn, flush, wr_en, rd_en;
    logic [1:0]    wr_lane;
    logic [W-1:0]  wr_data;
    logic [L*W-1:0] rd_data;
    logic [L-1:0]  lane_empty, lane_full;
    logic          all_valid, err_ovf, err_udf;

    logic          f3, w3_en, r3_en;
    logic [1:0]    w3_lane;
    logic [7:0]    w3_data;
    logic [23:0]   d3_rd_data;
    logic [2:0]    d3_empty, d3_full;
    logic          d3_all_valid, d3_ovf, d3_udf;

    int total = 0;
    int bad   = 0;

    logic [7:0] mq [L][$];
    logic       m_ovf, m_udf;
    logic [7:0] l3exp [4];

    always #5 clk = ~clk;

    skew_feed_buf #(.WORDLEN(W), .LANES(L), .DEPTH(D), .SKEW(S)) u_dut (
        .clk(clk), .rstn(rstn), .flush(flush), .wr_en(wr_en), .wr_lane(wr_lane),
        .wr_data(wr_data), .rd_en(rd_en), .rd_data(rd_data), .lane_empty(lane_empty),
        .lane_full(lane_full), .all_valid(all_valid), .err_ovf(err_ovf), .err_udf(err_udf)
    );

    skew_feed_buf #(.WORDLEN(8), .LANES(3), .DEPTH(5), .SKEW(2)) u_dut3 (
        .clk(clk), .rstn(rstn), .flush(f3), .wr_en(w3_en), .wr_lane(w3_lane),
        .wr_data(w3_data), .rd_en(r3_en), .rd_data(d3_rd_data), .lane_empty(d3_empty),
        .lane_full(d3_full), .all_valid(d3_all_valid), .err_ovf(d3_ovf), .err_udf(d3_udf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic we, input int lane, input logic [7:0] d,
                              input logic re, input logic fl, input logic rs);
        int   sz [L];
        logic any_empty;
        if (!rs || fl) begin
            for (int i = 0; i < L; i++) begin
                mq[i].delete();
                repeat (i * S) mq[i].push_back(8'h00);
            end
            if (!rs) begin
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end
        end else begin
            any_empty = 1'b0;
            for (int i = 0; i < L; i++) begin
                sz[i] = mq[i].size();
                if (sz[i] == 0) any_empty = 1'b1;
            end
            if (re && any_empty) m_udf = 1'b1;
            if (re) begin
                for (int i = 0; i < L; i++) begin
                    if (sz[i] > 0) void'(mq[i].pop_front());
                end
            end
            if (we && lane < L) begin
                if (sz[lane] < D || (re && sz[lane] > 0)) mq[lane].push_back(d);
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic check_model();
        logic [L*W-1:0] er;
        logic [L-1:0]   ee, ef;
        er = '0;
        for (int i = 0; i < L; i++) begin
            ee[i] = (mq[i].size() == 0);
            ef[i] = (mq[i].size() == D);
            if (mq[i].size() > 0) er[i*W +: W] = mq[i][0];
        end
        chk("m_rd_data", rd_data, er);
        chk("m_lane_empty", lane_empty, ee);
        chk("m_lane_full", lane_full, ef);
        chk("m_all_valid", all_valid, ~|ee);
        chk("m_err_ovf", err_ovf, m_ovf);
        chk("m_err_udf", err_udf, m_udf);
    endtask

    task automatic step(input logic we, input int lane, input logic [7:0] d,
                        input logic re, input logic fl, input logic rs);
        logic [1:0] ln;
        ln      = lane[1:0];
        wr_en   = we;
        wr_lane = ln;
        wr_data = d;
        rd_en   = re;
        flush   = fl;
        rstn    = rs;
        @(posedge clk);
        #1;
        model_step(we, lane, d, re, fl, rs);
        check_model();
    endtask

    initial begin
        {rstn, flush, wr_en, rd_en, wr_lane, wr_data} = '0;
        {f3, w3_en, r3_en, w3_lane, w3_data} = '0;
        l3exp = '{8'h00, 8'h00, 8'h00, 8'hA4};
        #2;
        step(0, 0, 8'h00, 0, 0, 0);
        step(0, 0, 8'h00, 0, 0, 0);
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_lane_empty", lane_empty, 4'b0001);
        chk("rst_lane_full", lane_full, 4'b0000);
        chk("rst_all_valid", all_valid, 1'b0);
        chk("rst_err_ovf", err_ovf, 1'b0);
        chk("rst_err_udf", err_udf, 1'b0);

        // Skewed feed: one word per lane, then broadcast pops.
        for (int i = 0; i < L; i++) step(1, i, 8'hA1 + 8'(i), 0, 0, 1);
        chk("t1_lane0_first", rd_data[7:0], 8'hA1);
        chk("t1_all_valid", all_valid, 1'b1);
        for (int k = 0; k < 4; k++) begin
            chk("t1_lane3_seq", rd_data[31:24], l3exp[k]);
            step(0, 0, 8'h00, 1, 0, 1);
            chk("t1_udf", err_udf, (k == 0) ? 1'b0 : 1'b1);
        end

        // Fill lane 1, overflow drop, then full-lane push with pop.
        step(0, 0, 8'h00, 0, 0, 0);
        for (int k = 0; k < 15; k++) step(1, 1, 8'h10 + 8'(k), 0, 0, 1);
        chk("t2_full", lane_full, 4'b0010);
        step(1, 1, 8'h55, 0, 0, 1);
        chk("t2_ovf", err_ovf, 1'b1);
        chk("t2_full_after_drop", lane_full, 4'b0010);
        step(1, 1, 8'h66, 1, 0, 1);
        chk("t2_full_after_pp", lane_full, 4'b0010);
        for (int k = 0; k < 16; k++) begin
            if (k == 15) chk("t2_last_word", rd_data[15:8], 8'h66);
            step(0, 0, 8'h00, 1, 0, 1);
        end
        chk("t2_drained", lane_empty, 4'b1111);

        // Mid-stream flush keeps sticky flags; reset clears them.
        step(1, 2, 8'h33, 0, 0, 1);
        step(1, 0, 8'h44, 0, 0, 1);
        step(1, 0, 8'h99, 1, 1, 1);
        chk("t3_flush_empty", lane_empty, 4'b0001);
        chk("t3_flush_data", rd_data, 32'h0);
        chk("t3_flush_ovf", err_ovf, 1'b1);
        chk("t3_flush_udf", err_udf, 1'b1);
        step(0, 0, 8'h00, 0, 0, 0);
        chk("t3_rst_ovf", err_ovf, 1'b0);
        chk("t3_rst_udf", err_udf, 1'b0);

        // Continuous push/pop on lane 0 across several pointer wraps.
        step(1, 0, 8'h00, 0, 0, 1);
        for (int k = 1; k < 40; k++) begin
            chk("t4_wrap_head", rd_data[7:0], 8'(k - 1));
            chk("t4_wrap_nonempty", lane_empty[0], 1'b0);
            step(1, 0, 8'(k), 1, 0, 1);
        end
        chk("t4_wrap_last", rd_data[7:0], 8'd39);
        step(0, 0, 8'h00, 1, 0, 1);
        chk("t4_wrap_empty", lane_empty[0], 1'b1);

        // Push and pop together on an empty lane: pop is a no-op, no bypass.
        step(0, 0, 8'h00, 0, 0, 0);
        chk("t5_before", rd_data[7:0], 8'h00);
        step(1, 0, 8'h77, 1, 0, 1);
        chk("t5_after", rd_data[7:0], 8'h77);
        chk("t5_udf", err_udf, 1'b1);
        step(0, 0, 8'h00, 1, 0, 1);
        chk("t5_count_one", lane_empty[0], 1'b1);

        // Out-of-range lane and non-power-of-two depth on the 3-lane instance.
        step(0, 0, 8'h00, 0, 0, 0);
        chk("t6_rst_empty", d3_empty, 3'b001);
        w3_en = 1'b1; w3_lane = 2'd3; w3_data = 8'hEE;
        step(0, 0, 8'h00, 0, 0, 1);
        chk("t6_oor_empty", d3_empty, 3'b001);
        chk("t6_oor_data", d3_rd_data, 24'h0);
        chk("t6_oor_full", d3_full, 3'b000);
        chk("t6_oor_ovf", d3_ovf, 1'b0);
        w3_lane = 2'd2; w3_data = 8'hC5;
        step(0, 0, 8'h00, 0, 0, 1);
        chk("t6_d5_full", d3_full, 3'b100);
        chk("t6_d5_ovf_clear", d3_ovf, 1'b0);
        step(0, 0, 8'h00, 0, 0, 1);
        chk("t6_d5_ovf", d3_ovf, 1'b1);
        w3_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
